test_block_buffer: RTL and testbench

//  Test-data stage fed by the backplane slow-control decoder.
//  - Captures one test block (fst/dav/lst/dat word stream) into an internal RAM.
//  - When enabled by test1/test2, replays the block toward transmitter input with rdy flow control.
//  - One instance sits per transmitter, between the decoder and the xmitter data mux.

---
 rtl/test_block_buffer.sv | 136 +++++++++++++
 tb/tb_test_block_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_block_buffer.sv
// rtl/test_block_buffer.sv - captures one test block into RAM and replays it with rdy flow control
// Optional repeat-with-gap playback is built when TESTBUF_LOOP_EN is defined.
module test_block_buffer #(
  parameter int AW         = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic          clk16,
  input  logic          reset,
  input  logic          test,
  input  logic          fsti,
  input  logic          davi,
  input  logic          lsti,
  input  logic [15:0]   dati,
  input  logic          rdy,
  output logic          fst_out,
  output logic          dav_out,
  output logic          lst_out,
  output logic [15:0]   dat_out,
  output logic [AW:0]   blk_len,
  output logic          ovf,
  output logic          busy
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [2:0] {IDLE, LOAD, READY, PLAY, GAP} state_t;

  state_t        state, state_n;
  logic [15:0]   ram [DEPTH];
  logic [AW:0]   wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] wr_addr;
  logic          test_d;
  logic          fresh;
  logic          accept, start, load_word, drop, bad_end;
  logic          issue, last_issue, wr_en;

`ifdef TESTBUF_LOOP_EN
  localparam int GW = $clog2(GAP_CYCLES + 1);
  logic [GW-1:0] gap_cnt;
`endif

  always_comb begin
    accept     = (state == IDLE) || (state == READY) || (state == LOAD);
    // Inside LOAD a bare lsti closes the block; only fsti restarts it.
    start      = accept && davi && (fsti || (lsti && (state != LOAD)));
    load_word  = (state == LOAD) && davi && !start;
    drop       = load_word && wptr[AW];
    bad_end    = ovf || drop;
    issue      = (state == PLAY) && rdy;
    last_issue = issue && ({1'b0, rptr} == blk_len - 1'b1);
    wr_en      = start || (load_word && !wptr[AW]);
    wr_addr    = start ? '0 : wptr[AW-1:0];
    state_n    = state;
    case (state)
      IDLE, READY, LOAD: begin
        if (start)
          state_n = lsti ? READY : LOAD;
        else if (load_word && lsti)
          state_n = bad_end ? IDLE : READY;
        else if ((state == READY) && test && (fresh || !test_d))
          state_n = PLAY;
      end
`ifdef TESTBUF_LOOP_EN
      PLAY: if (last_issue) state_n = GAP;
      GAP:  if (gap_cnt == '0) state_n = test ? PLAY : READY;
`else
      PLAY: if (last_issue) state_n = READY;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk16) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk16) begin
    if (wr_en) ram[wr_addr] <= dati;
  end

  always_ff @(posedge clk16) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      blk_len <= '0;
      ovf     <= 1'b0;
      fresh   <= 1'b0;
      test_d  <= 1'b0;
      fst_out <= 1'b0;
      dav_out <= 1'b0;
      lst_out <= 1'b0;
      dat_out <= '0;
    end else begin
      test_d  <= test;
      dav_out <= issue;
      fst_out <= issue && (rptr == '0);
      lst_out <= last_issue;
      dat_out <= issue ? ram[rptr] : '0;
      if (start) begin
        wptr    <= {{AW{1'b0}}, 1'b1};
        ovf     <= 1'b0;
        blk_len <= lsti ? {{AW{1'b0}}, 1'b1} : '0;
        fresh   <= lsti;
      end else if (load_word) begin
        // wptr saturates at DEPTH so every later word is seen as overflow
        if (wptr[AW]) ovf  <= 1'b1;
        else          wptr <= wptr + 1'b1;
        if (lsti) begin
          blk_len <= bad_end ? '0 : wptr + 1'b1;
          fresh   <= !bad_end;
        end
      end
      if (issue) rptr <= rptr + 1'b1;
      if ((state_n == PLAY) && (state != PLAY)) begin
        rptr  <= '0;
        fresh <= 1'b0;
      end
    end
  end

`ifdef TESTBUF_LOOP_EN
  always_ff @(posedge clk16) begin
    if (reset)
      gap_cnt <= '0;
    else if (last_issue)
      gap_cnt <= GW'(GAP_CYCLES - 1);
    else if ((state == GAP) && (gap_cnt != '0))
      gap_cnt <= gap_cnt - 1'b1;
  end
`endif

  assign busy = (state == PLAY) || (state == GAP);

endmodule

// File: tb/tb_test_block_buffer.sv
// tb/tb_test_block_buffer.sv - directed self-checking bench for test_block_buffer
module tb_test_block_buffer;

  logic        clk16 = 1'b0;
  logic        reset = 1'b1;
  logic        test  = 1'b0;
  logic        fsti  = 1'b0;
  logic        davi  = 1'b0;
  logic        lsti  = 1'b0;
  logic [15:0] dati  = '0;
  logic        rdy   = 1'b0;
  logic        fst_out, dav_out, lst_out, ovf, busy;
  logic [15:0] dat_out;
  logic [8:0]  blk_len;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int zero_bad = 0;
  logic [15:0] q_dat[$];
  logic        q_fst[$];
  logic        q_lst[$];
  int          q_idx[$];

  test_block_buffer #(.AW(8), .GAP_CYCLES(16)) dut (
    .clk16(clk16), .reset(reset), .test(test), .fsti(fsti), .davi(davi),
    .lsti(lsti), .dati(dati), .rdy(rdy), .fst_out(fst_out), .dav_out(dav_out),
    .lst_out(lst_out), .dat_out(dat_out), .blk_len(blk_len), .ovf(ovf), .busy(busy)
  );

  always #31 clk16 = ~clk16;

  task tick();
    @(posedge clk16);
    #1;
    cyc++;
  endtask

  task send_word(input logic f, input logic l, input logic [15:0] d);
    fsti = f; lsti = l; dati = d; davi = 1'b1;
    tick();
    davi = 1'b0; fsti = 1'b0; lsti = 1'b0; dati = '0;
  endtask

  task load_block(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) send_word(i == 0, i == n - 1, base + 16'(i));
    tick();
  endtask

  task clear_q();
    q_dat.delete(); q_fst.delete(); q_lst.delete(); q_idx.delete();
  endtask

  task collect(input int n);
    clear_q();
    for (int i = 0; i < n; i++) begin
      tick();
      if (dav_out) begin
        q_dat.push_back(dat_out); q_fst.push_back(fst_out);
        q_lst.push_back(lst_out); q_idx.push_back(cyc);
      end else if (dat_out !== 16'h0) zero_bad++;
    end
  endtask

  task settle();
    test = 1'b0;
    for (int i = 0; i < 64 && busy; i++) tick();
    tick();
  endtask

  task test_reset();
    reset = 1'b1;
    tick(); tick();
    tests++;
    if ({dav_out, fst_out, lst_out, dat_out, blk_len, ovf, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got dav=%b fst=%b lst=%b dat=%h len=%0d ovf=%b busy=%b, want all 0",
               dav_out, fst_out, lst_out, dat_out, blk_len, ovf, busy);
    end
    reset = 1'b0;
    tick();
  endtask

  task test_four_words();
    logic [15:0] exp_w [4];
    exp_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    rdy = 1'b1; test = 1'b0;
    for (int i = 0; i < 4; i++) send_word(i == 0, i == 3, exp_w[i]);
    tick();
    tests++;
    if (blk_len !== 9'd4 || busy !== 1'b0) begin
      fails++; $display("FAIL four_len: got len=%0d busy=%b, want len=4 busy=0", blk_len, busy);
    end
    zero_bad = 0;
    test = 1'b1;
    collect(16);
    tests++;
    if (q_dat.size() !== 4) begin
      fails++; $display("FAIL four_count: got %0d words, want 4", q_dat.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (q_dat[i] !== exp_w[i] || q_fst[i] !== (i == 0) || q_lst[i] !== (i == 3)) begin
          fails++;
          $display("FAIL four_word[%0d]: got dat=%h fst=%b lst=%b, want dat=%h fst=%b lst=%b",
                   i, q_dat[i], q_fst[i], q_lst[i], exp_w[i], i == 0, i == 3);
        end
      end
      tests++;
      if (q_idx[3] - q_idx[0] !== 3) begin
        fails++; $display("FAIL four_consecutive: got span %0d, want 3", q_idx[3] - q_idx[0]);
      end
    end
    tests++;
    if (zero_bad !== 0) begin
      fails++; $display("FAIL dat_zero_idle: got %0d nonzero idle cycles, want 0", zero_bad);
    end
  endtask

  task test_single();
    test = 1'b1; rdy = 1'b1;
    send_word(1'b0, 1'b1, 16'hBEEF);
    collect(8);
    tests++;
    if (q_dat.size() !== 1) begin
      fails++; $display("FAIL single_count: got %0d words, want 1", q_dat.size());
    end else begin
      tests++;
      if (q_dat[0] !== 16'hBEEF || q_fst[0] !== 1'b1 || q_lst[0] !== 1'b1) begin
        fails++;
        $display("FAIL single_word: got dat=%h fst=%b lst=%b, want dat=beef fst=1 lst=1",
                 q_dat[0], q_fst[0], q_lst[0]);
      end
    end
    tests++;
    if (blk_len !== 9'd1) begin
      fails++; $display("FAIL single_len: got %0d, want 1", blk_len);
    end
  endtask

  task test_rdy_toggle();
    bit   pat [4];
    logic prev;
    int   bad, n;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    settle();
    rdy = 1'b0;
    load_block(8, 16'h5000);
    test = 1'b1;
    for (int w = 0; w < 10 && !busy; w++) tick();
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL rdy_arm: got busy=%b, want 1", busy);
    end
    clear_q();
    bad = 0; n = 0;
    rdy = pat[0]; prev = rdy;
    for (int i = 1; i < 64 && n < 8; i++) begin
      tick();
      if (dav_out !== prev) bad++;
      if (dav_out) begin
        q_dat.push_back(dat_out); q_fst.push_back(fst_out); q_lst.push_back(lst_out); n++;
      end
      rdy = pat[i % 4]; prev = rdy;
    end
    rdy = 1'b1;
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL rdy_dav_follow: got %0d cycles where dav differs from prior rdy, want 0", bad);
    end
    tests++;
    if (n !== 8) begin
      fails++; $display("FAIL rdy_count: got %0d words, want 8", n);
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (q_dat[i] !== 16'h5000 + 16'(i) || q_fst[i] !== (i == 0) || q_lst[i] !== (i == 7)) begin
          fails++;
          $display("FAIL rdy_word[%0d]: got dat=%h fst=%b lst=%b, want dat=%h fst=%b lst=%b",
                   i, q_dat[i], q_fst[i], q_lst[i], 16'h5000 + 16'(i), i == 0, i == 7);
        end
      end
    end
  endtask

  task test_ignore_play();
    settle();
    rdy = 1'b0;
    load_block(6, 16'h6000);
    test = 1'b1;
    for (int w = 0; w < 10 && !busy; w++) tick();
    send_word(1'b1, 1'b0, 16'hDEAD);
    send_word(1'b0, 1'b0, 16'hBEEF);
    send_word(1'b0, 1'b1, 16'hCAFE);
    tests++;
    if (blk_len !== 9'd6 || busy !== 1'b1) begin
      fails++; $display("FAIL ignore_len: got len=%0d busy=%b, want len=6 busy=1", blk_len, busy);
    end
    rdy = 1'b1; test = 1'b0;
    collect(16);
    tests++;
    if (q_dat.size() !== 6) begin
      fails++; $display("FAIL ignore_count: got %0d words, want 6", q_dat.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (q_dat[i] !== 16'h6000 + 16'(i)) begin
          fails++; $display("FAIL ignore_word[%0d]: got %h, want %h", i, q_dat[i], 16'h6000 + 16'(i));
        end
      end
    end
    tests++;
    if (blk_len !== 9'd6 || busy !== 1'b0) begin
      fails++; $display("FAIL ignore_after: got len=%0d busy=%b, want len=6 busy=0", blk_len, busy);
    end
  endtask

  task test_overflow();
    settle();
    rdy = 1'b1;
    load_block(256, 16'h0000);
    tests++;
    if (blk_len !== 9'd256 || ovf !== 1'b0) begin
      fails++; $display("FAIL full_depth: got len=%0d ovf=%b, want len=256 ovf=0", blk_len, ovf);
    end
    load_block(259, 16'h0100);
    tests++;
    if (blk_len !== 9'd0 || ovf !== 1'b1) begin
      fails++; $display("FAIL ovf_set: got len=%0d ovf=%b, want len=0 ovf=1", blk_len, ovf);
    end
    test = 1'b1;
    collect(8);
    tests++;
    if (q_dat.size() !== 0 || busy !== 1'b0) begin
      fails++; $display("FAIL ovf_no_play: got %0d words busy=%b, want 0 words busy=0", q_dat.size(), busy);
    end
    test = 1'b0;
    tick();
    send_word(1'b1, 1'b0, 16'hA1A1);
    tests++;
    if (ovf !== 1'b0 || blk_len !== 9'd0) begin
      fails++; $display("FAIL ovf_clear_start: got ovf=%b len=%0d, want ovf=0 len=0", ovf, blk_len);
    end
    send_word(1'b0, 1'b1, 16'hA2A2);
    tick();
    tests++;
    if (ovf !== 1'b0 || blk_len !== 9'd2) begin
      fails++; $display("FAIL ovf_reload: got ovf=%b len=%0d, want ovf=0 len=2", ovf, blk_len);
    end
  endtask

  task test_reset_mid_play();
    settle();
    rdy = 1'b1;
    load_block(5, 16'h7000);
    test = 1'b1;
    for (int w = 0; w < 10 && !dav_out; w++) tick();
    tests++;
    if (dav_out !== 1'b1) begin
      fails++; $display("FAIL rmp_started: got dav=%b, want 1", dav_out);
    end
    reset = 1'b1;
    tick();
    tests++;
    if ({dav_out, fst_out, lst_out, dat_out, blk_len, ovf, busy} !== '0) begin
      fails++;
      $display("FAIL rmp_outputs: got dav=%b fst=%b lst=%b dat=%h len=%0d ovf=%b busy=%b, want all 0",
               dav_out, fst_out, lst_out, dat_out, blk_len, ovf, busy);
    end
    reset = 1'b0; test = 1'b0;
    tick();
    test = 1'b1;
    collect(8);
    tests++;
    if (q_dat.size() !== 0) begin
      fails++; $display("FAIL rmp_no_replay: got %0d words, want 0", q_dat.size());
    end
    test = 1'b0;
  endtask

`ifdef TESTBUF_LOOP_EN
  task test_loop();
    settle();
    rdy = 1'b1;
    load_block(3, 16'h9000);
    clear_q();
    test = 1'b1;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (dav_out) begin
        q_dat.push_back(dat_out); q_fst.push_back(fst_out); q_idx.push_back(cyc);
        if (q_dat.size() == 4) test = 1'b0;
      end
    end
    tests++;
    if (q_dat.size() !== 6) begin
      fails++; $display("FAIL loop_count: got %0d words, want 6", q_dat.size());
    end else begin
      tests++;
      if (q_idx[3] - q_idx[2] !== 17 || q_idx[5] - q_idx[3] !== 2) begin
        fails++; $display("FAIL loop_gap: got spacing %0d/%0d, want 17/2",
                          q_idx[3] - q_idx[2], q_idx[5] - q_idx[3]);
      end
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (q_dat[i] !== 16'h9000 + 16'(i % 3) || q_fst[i] !== (i % 3 == 0)) begin
          fails++; $display("FAIL loop_word[%0d]: got dat=%h fst=%b, want dat=%h fst=%b",
                            i, q_dat[i], q_fst[i], 16'h9000 + 16'(i % 3), i % 3 == 0);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_four_words();
    test_single();
    test_rdy_toggle();
    test_ignore_play();
    test_overflow();
    test_reset_mid_play();
`ifdef TESTBUF_LOOP_EN
    test_loop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
